// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and PC constants.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } pc_sel_e;

  localparam int INSTR_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full
// overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            empty;

  assign top_idx = ptr_q - 1'b1;
  assign empty   = (cnt_q == '0);

  // ptr_q is the next free slot; once full it also marks the oldest entry
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  assign top   = mem_q[top_idx];
  assign count = cnt_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select, alignment
// check and return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Stall,
  input  logic                         Branch_taken,
  input  logic [XLEN-1:0]              Branch_target,
  input  logic                         Jump,
  input  logic [XLEN-1:0]              Jump_target,
  input  logic                         Call,
  input  logic                         Ret,
  output logic [XLEN-1:0]              Pc_out,
  output logic [XLEN-1:0]              Pc_plus4,
  output logic                         Misaligned,
  output logic                         Ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]   Ras_count
);

  logic [XLEN-1:0]            pc_q, pc_d;
  logic                       mis_q, mis_d;
  logic                       unf_q, unf_d;
  logic [XLEN-1:0]            ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  logic                       ras_empty;
  logic                       ras_push, ras_pop;
  pc_sel_e                    sel;
  logic [XLEN-1:0]            tgt;
  logic                       use_tgt;
  logic                       bad_tgt;

  assign Pc_plus4  = pc_q + XLEN'(INSTR_BYTES);
  assign ras_empty = (ras_cnt == '0);
  assign ras_push  = !Stall && Jump && Call;
  assign ras_pop   = !Stall && Ret;

  always_comb begin
    sel = SEL_SEQ;
    if (Ret) begin
      sel = SEL_RET;
    end else if (Jump) begin
      sel = SEL_JMP;
    end else if (Branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    tgt     = Pc_plus4;
    use_tgt = 1'b0;
    unique case (sel)
      SEL_RET: begin
        tgt     = ras_top;
        use_tgt = !ras_empty;
      end
      SEL_JMP: begin
        tgt     = Jump_target;
        use_tgt = 1'b1;
      end
      SEL_BR: begin
        tgt     = Branch_target;
        use_tgt = 1'b1;
      end
      default: begin
        use_tgt = 1'b0;
      end
    endcase
  end

  // a misaligned target falls back to sequential flow
  always_comb begin
    bad_tgt = use_tgt && (tgt[1:0] != 2'b00);
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unf_d   = 1'b0;
    if (!Stall) begin
      pc_d  = (use_tgt && !bad_tgt) ? tgt : Pc_plus4;
      mis_d = bad_tgt;
      unf_d = Ret && ras_empty;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst       (Rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (Pc_plus4),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  assign Pc_out        = pc_q;
  assign Misaligned    = mis_q;
  assign Ras_underflow = unf_q;
  assign Ras_count     = ras_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed tests for pc_unit (32-bit, reset 0x100)
// plus a 16-bit instance for increment wrap.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_t = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_t = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc, pc4;
  logic        mis, unf;
  logic [2:0]  cnt;

  logic        rst_h = 1'b0;
  logic        jmp_h = 1'b0;
  logic [15:0] jmp_t_h = '0;
  logic [15:0] pc_h, pc4_h;
  logic        mis_h, unf_h;
  logic [2:0]  cnt_h;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (4)
  ) u_dut (
    .Clk           (clk),
    .Rst           (rst),
    .Stall         (stall),
    .Branch_taken  (br),
    .Branch_target (br_t),
    .Jump          (jmp),
    .Jump_target   (jmp_t),
    .Call          (call),
    .Ret           (ret),
    .Pc_out        (pc),
    .Pc_plus4      (pc4),
    .Misaligned    (mis),
    .Ras_underflow (unf),
    .Ras_count     (cnt)
  );

  pc_unit #(
    .XLEN      (16),
    .RAS_DEPTH (4)
  ) u_dut16 (
    .Clk           (clk),
    .Rst           (rst_h),
    .Stall         (1'b0),
    .Branch_taken  (1'b0),
    .Branch_target (16'h0),
    .Jump          (jmp_h),
    .Jump_target   (jmp_t_h),
    .Call          (1'b0),
    .Ret           (1'b0),
    .Pc_out        (pc_h),
    .Pc_plus4      (pc4_h),
    .Misaligned    (mis_h),
    .Ras_underflow (unf_h),
    .Ras_count     (cnt_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; br = 0; jmp = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    step();
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h100); end
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    checks++; if (mis !== 1'b0 || unf !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", mis, unf); end
    checks++; if (pc4 !== 32'h104) begin failures++; $display("FAIL rst_plus4 got=%h exp=%h", pc4, 32'h104); end
    rst = 0;
    step();
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL seq1 got=%h exp=%h", pc, 32'h104); end
    step();
    checks++; if (pc !== 32'h108) begin failures++; $display("FAIL seq2 got=%h exp=%h", pc, 32'h108); end
    step();
    checks++; if (pc !== 32'h10C) begin failures++; $display("FAIL seq3 got=%h exp=%h", pc, 32'h10C); end
  endtask

  task automatic test_branch_jump_stall();
    idle();
    jmp = 1; jmp_t = 32'h10;
    step();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL jmp got=%h exp=%h", pc, 32'h10); end
    br = 1; br_t = 32'h40; jmp_t = 32'h80;
    step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL jmp_over_br got=%h exp=%h", pc, 32'h80); end
    idle();
    stall = 1; jmp = 1; jmp_t = 32'h200; call = 1; ret = 1;
    step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL stall1 got=%h exp=%h", pc, 32'h80); end
    checks++; if (cnt !== 3'd0 || unf !== 1'b0) begin failures++; $display("FAIL stall_ras got=%0d/%b exp=0/0", cnt, unf); end
    step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL stall2 got=%h exp=%h", pc, 32'h80); end
    idle();
    step();
    checks++; if (pc !== 32'h84) begin failures++; $display("FAIL unstall got=%h exp=%h", pc, 32'h84); end
    br = 1; br_t = 32'h40;
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL branch got=%h exp=%h", pc, 32'h40); end
    idle();
    call = 1;
    step();
    checks++; if (pc !== 32'h44 || cnt !== 3'd0) begin failures++; $display("FAIL call_only got=%h/%0d exp=44/0", pc, cnt); end
    idle();
  endtask

  task automatic test_ras();
    logic [31:0] tg [5];
    logic [31:0] rp [4];
    tg = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hA0};
    rp = '{32'h84, 32'h64, 32'h44, 32'h24};
    idle();
    jmp = 1; jmp_t = 32'h0;
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL ras_start got=%h exp=0", pc); end
    for (int i = 0; i < 5; i++) begin
      jmp = 1; call = 1; jmp_t = tg[i];
      step();
      checks++; if (pc !== tg[i]) begin failures++; $display("FAIL call%0d_pc got=%h exp=%h", i, pc, tg[i]); end
      checks++; if (cnt !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin failures++; $display("FAIL call%0d_cnt got=%0d", i, cnt); end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      step();
      checks++; if (pc !== rp[i]) begin failures++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc, rp[i]); end
      checks++; if (cnt !== 3'(3 - i) || unf !== 1'b0) begin failures++; $display("FAIL ret%0d_cnt got=%0d/%b exp=%0d/0", i, cnt, unf, 3 - i); end
    end
    step();
    checks++; if (pc !== 32'h28 || unf !== 1'b1 || cnt !== 3'd0) begin failures++; $display("FAIL underflow got=%h/%b/%0d exp=28/1/0", pc, unf, cnt); end
    idle();
    step();
    checks++; if (pc !== 32'h2C || unf !== 1'b0) begin failures++; $display("FAIL unf_pulse got=%h/%b exp=2c/0", pc, unf); end
  endtask

  task automatic test_ret_call_same();
    idle();
    ret = 1; jmp = 1; call = 1; jmp_t = 32'h300;
    step();
    checks++; if (pc !== 32'h30 || unf !== 1'b1 || cnt !== 3'd1) begin failures++; $display("FAIL rc_empty got=%h/%b/%0d exp=30/1/1", pc, unf, cnt); end
    idle();
    ret = 1;
    step();
    checks++; if (pc !== 32'h30 || cnt !== 3'd0 || unf !== 1'b0) begin failures++; $display("FAIL rc_pop got=%h/%0d/%b exp=30/0/0", pc, cnt, unf); end
    idle();
    jmp = 1; call = 1; jmp_t = 32'h400;
    step();
    ret = 1; jmp_t = 32'h500;
    step();
    checks++; if (pc !== 32'h34 || cnt !== 3'd1) begin failures++; $display("FAIL rc_swap got=%h/%0d exp=34/1", pc, cnt); end
    idle();
    ret = 1;
    step();
    checks++; if (pc !== 32'h404 || cnt !== 3'd0) begin failures++; $display("FAIL rc_top got=%h/%0d exp=404/0", pc, cnt); end
    idle();
  endtask

  task automatic test_misaligned();
    idle();
    jmp = 1; jmp_t = 32'h10;
    step();
    jmp_t = 32'h202;
    step();
    checks++; if (pc !== 32'h14 || mis !== 1'b1) begin failures++; $display("FAIL mis_jmp got=%h/%b exp=14/1", pc, mis); end
    idle();
    step();
    checks++; if (pc !== 32'h18 || mis !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%h/%b exp=18/0", pc, mis); end
    br = 1; br_t = 32'h41;
    step();
    checks++; if (pc !== 32'h1C || mis !== 1'b1) begin failures++; $display("FAIL mis_br got=%h/%b exp=1c/1", pc, mis); end
    idle();
    jmp = 1; call = 1; jmp_t = 32'h302;
    step();
    checks++; if (pc !== 32'h20 || mis !== 1'b1 || cnt !== 3'd1) begin failures++; $display("FAIL mis_call got=%h/%b/%0d exp=20/1/1", pc, mis, cnt); end
    idle();
    ret = 1;
    step();
    checks++; if (pc !== 32'h20 || mis !== 1'b0 || cnt !== 3'd0) begin failures++; $display("FAIL mis_ret got=%h/%b/%0d exp=20/0/0", pc, mis, cnt); end
    idle();
  endtask

  task automatic test_reset_override();
    idle();
    for (int i = 0; i < 3; i++) begin
      jmp = 1; call = 1; jmp_t = 32'h600 + 32'(i * 16);
      step();
    end
    checks++; if (cnt !== 3'd3) begin failures++; $display("FAIL pre_rst_cnt got=%0d exp=3", cnt); end
    call = 0;
    rst = 1; stall = 1; jmp = 1; jmp_t = 32'h700;
    step();
    checks++; if (pc !== 32'h100 || cnt !== 3'd0) begin failures++; $display("FAIL rst_ovr got=%h/%0d exp=100/0", pc, cnt); end
    idle();
    ret = 1;
    step();
    checks++; if (pc !== 32'h104 || unf !== 1'b1) begin failures++; $display("FAIL rst_discard got=%h/%b exp=104/1", pc, unf); end
    idle();
  endtask

  task automatic test_wrap16();
    rst_h = 1;
    step();
    checks++; if (pc_h !== 16'h0 || cnt_h !== 3'd0) begin failures++; $display("FAIL w16_rst got=%h/%0d exp=0/0", pc_h, cnt_h); end
    rst_h = 0; jmp_h = 1; jmp_t_h = 16'hFFFC;
    step();
    checks++; if (pc_h !== 16'hFFFC || pc4_h !== 16'h0) begin failures++; $display("FAIL w16_top got=%h/%h exp=fffc/0", pc_h, pc4_h); end
    jmp_h = 0;
    step();
    checks++; if (pc_h !== 16'h0 || mis_h !== 1'b0 || unf_h !== 1'b0) begin failures++; $display("FAIL w16_wrap got=%h/%b%b exp=0/00", pc_h, mis_h, unf_h); end
  endtask

  initial begin
    test_reset();
    test_branch_jump_stall();
    test_ras();
    test_ret_call_same();
    test_misaligned();
    test_reset_override();
    test_wrap16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
